// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - snapshots an 8x8 PE result array and streams it row by row with shift/saturate
module systolic_drain #(
    parameter int PE_OUT_WIDTH = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int SHIFT        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture_in,
    input  logic [8*8*PE_OUT_WIDTH-1:0]  res_in,
    output logic [8*OUT_WIDTH-1:0]       out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_row,
    output logic                         out_last,
    output logic [7:0]                   out_sat,
    output logic                         busy,
    output logic                         capture_drop
);

    localparam int ROW_BITS = 8 * PE_OUT_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  row_q, row_d;
    logic                        drop_q, drop_d;
    logic                        load;
    logic [8*8*PE_OUT_WIDTH-1:0] buf_q;
    logic [ROW_BITS-1:0]         row_sel;
    logic [7:0]                  lane_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drop_q  <= drop_d;
        end
    end

    // The snapshot buffer needs no reset: nothing reads it outside STREAM.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_q <= res_in;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drop_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_in) begin
                    load    = 1'b1;
                    row_d   = 3'd0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (row_q == 3'd7) begin
                        row_d = 3'd0;
                        if (capture_in) begin
                            // Back-to-back snapshot: refill on the final beat with no bubble.
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
                if (capture_in && !(out_ready && row_q == 3'd7)) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        row_sel = '0;
        for (int r = 0; r < 8; r++) begin
            if (row_q == 3'(r)) begin
                row_sel = buf_q[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    for (genvar j = 0; j < 8; j++) begin : g_lane
        logic signed [PE_OUT_WIDTH-1:0]        elem;
        logic signed [PE_OUT_WIDTH-1:0]        shifted;
        logic [PE_OUT_WIDTH-OUT_WIDTH:0]       hi;
        logic                                  in_range;
        logic [OUT_WIDTH-1:0]                  lane_val;

        assign elem     = row_sel[j*PE_OUT_WIDTH +: PE_OUT_WIDTH];
        assign shifted  = elem >>> SHIFT;
        // In range exactly when every bit above the output sign bit matches it.
        assign hi       = shifted[PE_OUT_WIDTH-1:OUT_WIDTH-1];
        assign in_range = (&hi) | ~(|hi);
        assign lane_val = in_range ? shifted[OUT_WIDTH-1:0] :
                          (shifted[PE_OUT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}});
        assign lane_sat[j] = ~in_range;
        assign out_data[j*OUT_WIDTH +: OUT_WIDTH] = out_valid ? lane_val : '0;
    end

    assign out_valid    = (state_q == STREAM);
    assign busy         = out_valid;
    assign out_row      = out_valid ? row_q : 3'd0;
    assign out_last     = out_valid && (row_q == 3'd7);
    assign out_sat      = out_valid ? lane_sat : 8'd0;
    assign capture_drop = drop_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - directed self-checking bench for systolic_drain
module tb_systolic_drain;

    localparam int PW = 32;
    localparam int OW = 16;

    logic            clk;
    logic            reset;
    logic            capture_in;
    logic [2047:0]   res_in;
    logic            out_ready;

    logic [127:0]    out_data;
    logic            out_valid;
    logic [2:0]      out_row;
    logic            out_last;
    logic [7:0]      out_sat;
    logic            busy;
    logic            capture_drop;

    logic [127:0]    s4_data;
    logic            s4_valid;
    logic [2:0]      s4_row;
    logic            s4_last;
    logic [7:0]      s4_sat;
    logic            s4_busy;
    logic            s4_drop;

    int checks = 0;
    int errors = 0;

    systolic_drain #(.PE_OUT_WIDTH(PW), .OUT_WIDTH(OW), .SHIFT(0)) u_dut (
        .clk(clk), .reset(reset), .capture_in(capture_in), .res_in(res_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .out_sat(out_sat),
        .busy(busy), .capture_drop(capture_drop)
    );

    systolic_drain #(.PE_OUT_WIDTH(PW), .OUT_WIDTH(OW), .SHIFT(4)) u_dut_s4 (
        .clk(clk), .reset(reset), .capture_in(capture_in), .res_in(res_in),
        .out_data(s4_data), .out_valid(s4_valid), .out_ready(out_ready),
        .out_row(s4_row), .out_last(s4_last), .out_sat(s4_sat),
        .busy(s4_busy), .capture_drop(s4_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        res_in = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                res_in[(j+8*i)*PW +: PW] = 32'(base + 16*i + j);
    endtask

    function automatic logic [127:0] exp_row(input int base, input int r);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 8; j++)
            v[j*OW +: OW] = 16'(base + 16*r + j);
        return v;
    endfunction

    task automatic pulse_capture();
        capture_in = 1'b1;
        step();
        capture_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        capture_in = 1'b1;
        out_ready = 1'b1;
        fill(0);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || capture_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b drop=%b expected 0 0 0", out_valid, busy, capture_drop);
        end
        checks++;
        if (out_data !== 128'd0 || out_row !== 3'd0 || out_last !== 1'b0 || out_sat !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h row=%0d last=%b sat=%h expected zeros", out_data, out_row, out_last, out_sat);
        end
        capture_in = 1'b0;
        #3 reset = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic_drain();
        fill(0);
        out_ready = 1'b1;
        pulse_capture();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: valid=%b busy=%b expected 1 1", out_valid, busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== 3'(i) || out_data !== exp_row(0, i) ||
                out_last !== (i == 7) || out_sat !== 8'd0) begin
                errors++;
                $display("FAIL basic_row%0d: valid=%b row=%0d last=%b sat=%h data=%h expected row %0d data %h",
                         i, out_valid, out_row, out_last, out_sat, out_data, i, exp_row(0, i));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b busy=%b last=%b expected 0 0 0", out_valid, busy, out_last);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int exp_r;
        int cyc;
        pat = 4'b1001;
        exp_r = 0;
        cyc = 0;
        fill(32);
        pulse_capture();
        while (exp_r < 8 && cyc < 64) begin
            out_ready = pat[cyc % 4];
            checks++;
            if (out_valid !== 1'b1 || out_row !== 3'(exp_r) || out_data !== exp_row(32, exp_r) ||
                out_last !== (exp_r == 7)) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b row=%0d last=%b data=%h expected row %0d data %h",
                         cyc, out_valid, out_row, out_last, out_data, exp_r, exp_row(32, exp_r));
            end
            step();
            if (out_ready) exp_r++;
            cyc++;
        end
        checks++;
        if (exp_r != 8 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: rows=%0d valid=%b busy=%b expected 8 0 0", exp_r, out_valid, busy);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        res_in = '0;
        res_in[0*PW +: PW] = 32'h0001_0000;
        res_in[1*PW +: PW] = 32'hFFFE_0000;
        res_in[2*PW +: PW] = 32'h0000_1234;
        out_ready = 1'b0;
        pulse_capture();
        checks++;
        if (out_data[47:0] !== 48'h1234_8000_7FFF || out_sat !== 8'b0000_0011) begin
            errors++;
            $display("FAIL sat_shift0: lanes=%h sat=%b expected 123480007fff 00000011", out_data[47:0], out_sat);
        end
        checks++;
        if (s4_data[47:0] !== 48'h0123_E000_1000 || s4_sat !== 8'd0) begin
            errors++;
            $display("FAIL sat_shift4: lanes=%h sat=%b expected 0123e0001000 00000000", s4_data[47:0], s4_sat);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (out_valid !== 1'b0 || s4_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_done: valid=%b s4_valid=%b expected 0 0", out_valid, s4_valid);
        end
    endtask

    task automatic test_capture_overlap();
        fill(0);
        out_ready = 1'b1;
        pulse_capture();
        for (int i = 0; i < 3; i++) step();
        fill(512);
        out_ready = 1'b0;
        pulse_capture();
        checks++;
        if (capture_drop !== 1'b1 || out_row !== 3'd3 || out_data !== exp_row(0, 3)) begin
            errors++;
            $display("FAIL ovl_drop: drop=%b row=%0d data=%h expected 1 3 %h", capture_drop, out_row, out_data, exp_row(0, 3));
        end
        step();
        checks++;
        if (capture_drop !== 1'b0 || out_row !== 3'd3) begin
            errors++;
            $display("FAIL ovl_drop_pulse: drop=%b row=%0d expected 0 3", capture_drop, out_row);
        end
        out_ready = 1'b1;
        for (int r = 3; r < 8; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== 3'(r) || out_data !== exp_row(0, r) || out_last !== (r == 7)) begin
                errors++;
                $display("FAIL ovl_old_row%0d: row=%0d last=%b data=%h expected data %h", r, out_row, out_last, out_data, exp_row(0, r));
            end
            if (r < 7) step();
        end
        pulse_capture();
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== 3'(r) || out_data !== exp_row(512, r) || capture_drop !== 1'b0) begin
                errors++;
                $display("FAIL ovl_new_row%0d: valid=%b row=%0d drop=%b data=%h expected data %h",
                         r, out_valid, out_row, capture_drop, out_data, exp_row(512, r));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovl_done: valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_mid_reset();
        fill(0);
        out_ready = 1'b1;
        pulse_capture();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (out_row !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mrst_pre: row=%0d valid=%b expected 3 1", out_row, out_valid);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'd0 || out_row !== 3'd0) begin
            errors++;
            $display("FAIL mrst_async: valid=%b busy=%b row=%0d data=%h expected 0 0 0 0", out_valid, busy, out_row, out_data);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mrst_after%0d: valid=%b busy=%b expected 0 0", i, out_valid, busy);
            end
        end
        fill(256);
        pulse_capture();
        checks++;
        if (out_valid !== 1'b1 || out_row !== 3'd0 || out_data !== exp_row(256, 0)) begin
            errors++;
            $display("FAIL mrst_recapture: valid=%b row=%0d data=%h expected 1 0 %h", out_valid, out_row, out_data, exp_row(256, 0));
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        reset = 1'b0;
        capture_in = 1'b0;
        out_ready = 1'b0;
        res_in = '0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_saturation();
        test_capture_overlap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter PE_OUT_WIDTH, default 32, meaning the signed two's-complement width of each array result element.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning the width of each streamed output lane (OUT_WIDTH <= PE_OUT_WIDTH).
REQ-003 SHALL have parameter SHIFT, default 0, meaning the arithmetic right-shift applied to each element before saturation (0..PE_OUT_WIDTH-1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port capture_in, input, 1, meaning a single-cycle request to snapshot the 8x8 array result.
REQ-007 SHALL have port res_in, input, 8*8*PE_OUT_WIDTH, meaning the array result bus; element (row i, col j) is at bit offset (j+8*i)*PE_OUT_WIDTH.
REQ-008 SHALL have port out_data, output, 8*OUT_WIDTH, meaning one result row; lane j is at bit offset j*OUT_WIDTH.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data, out_row, out_last and out_sat are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the downstream accepts the current beat.
REQ-011 SHALL have port out_row, output, 3, meaning the row index (0..7) of the current beat.
REQ-012 SHALL have port out_last, output, 1, meaning the current beat is row 7.
REQ-013 SHALL have port out_sat, output, 8, meaning bit j is set when lane j of the current beat saturated.
REQ-014 SHALL have port busy, output, 1, meaning a snapshot is held and not fully drained.
REQ-015 SHALL have port capture_drop, output, 1, meaning a single-cycle pulse when capture_in was ignored.

Function
REQ-016 SHALL implement two states: IDLE (no valid snapshot) and STREAM (snapshot held, rows being emitted).
REQ-017 SHALL, in IDLE with capture_in=1 at a rising edge, latch all 64 elements of res_in into an internal buffer, set the row counter to 0, and enter STREAM.
REQ-018 SHALL assert out_valid and busy in the cycle immediately after the capturing edge (one-cycle latency), presenting row 0.
REQ-019 SHALL assert out_valid if and only if the state is STREAM.
REQ-020 SHALL complete a transfer on any rising edge where out_valid=1 and out_ready=1, and increment the row counter on that edge.
REQ-021 SHALL hold out_data, out_row, out_last and out_sat stable while out_valid=1 and out_ready=0; the buffer SHALL NOT change while in STREAM.
REQ-022 SHALL drive out_last=1 exactly when out_row=7 and out_valid=1.
REQ-023 SHALL return to IDLE after the row-7 transfer, deasserting out_valid and busy the next cycle, unless REQ-024 applies.
REQ-024 SHALL, when capture_in=1 coincides with the row-7 transfer edge, accept the new snapshot, remain in STREAM with row 0, and keep out_valid high (back-to-back, no bubble).
REQ-025 SHALL ignore capture_in in STREAM other than in REQ-024, leave the buffer unchanged, and pulse capture_drop high for one cycle.
REQ-026 SHALL compute lane j of the current beat from element (out_row, j) as follows: sign-extend, arithmetic-shift right by SHIFT, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-027 SHALL set out_sat[j]=1 when the shifted value of lane j lies outside that range, and 0 otherwise.
REQ-028 SHALL NOT depend on out_ready for out_valid (out_valid never waits on out_ready).

Reset
REQ-029 SHALL, while reset=0 and regardless of clk, force state IDLE, row counter 0, out_valid 0, busy 0, capture_drop 0, out_row 0, out_last 0, out_sat 0, and out_data 0.
REQ-030 SHALL discard a partially drained snapshot on reset assertion mid-STREAM; no further beats of it are emitted after release.
REQ-031 SHALL ignore capture_in during the cycle reset is deasserted only if reset is still low at that edge; the first edge with reset=1 behaves normally.

Verification
REQ-032 SHALL cover basic drain: element(i,j)=16*i+j, SHIFT=0, out_ready=1, capture pulse -> 8 consecutive beats, rows 0..7, lane j of row i = 16*i+j, out_last only on row 7, out_sat=0, then busy=0.
REQ-033 SHALL cover backpressure: out_ready toggled 1,0,0,1,... -> each row emitted exactly once and in order, with data held stable during stalls.
REQ-034 SHALL cover saturation: element(0,0)=0x0001_0000, element(0,1)=0xFFFE_0000, element(0,2)=0x0000_1234, SHIFT=0, OUT_WIDTH=16 -> lanes 0x7FFF, 0x8000, 0x1234; out_sat[2:0]=011. With SHIFT=4, element 0x0001_0000 -> 0x1000, not saturated.
REQ-035 SHALL cover capture overlap: capture at row 3 -> capture_drop pulses and old data continues; capture on the row-7 transfer edge -> next beat is row 0 of the new data with no idle cycle.
REQ-036 SHALL cover mid-stream reset: reset low asynchronously after row 2 -> out_valid falls without a clock edge; after release, out_valid stays 0 until the next capture.
